// File: rtl/mem_access_unit.sv
// Dual-lane load/store initiator for the data memory.
// Accepts one two-lane request bundle, issues it to the memory through
// active-low strobes, captures load data and returns one response pulse.
// Same-address hazards involving a store are split into two issue cycles,
// lane 1 first, so the memory observes the lanes in program order.
//
// state  | meaning
// IDLE   | ready for a new bundle; req_ready high outside reset
// ISSUE  | lane 1 (and lane 2 when there is no hazard) driven to memory
// ISSUE2 | hazard only: lane 2 driven alone
// RESP   | one-cycle response pulse for each accepted lane
module mem_access_unit #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h10000000,
  parameter int                NUM_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_1,
  input  logic              req_valid_2,
  input  logic              req_we_1,
  input  logic              req_we_2,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [DATA_W-1:0] req_wdata_1,
  input  logic [DATA_W-1:0] req_wdata_2,
  output logic              req_ready,
  output logic              resp_valid_1,
  output logic              resp_valid_2,
  output logic [DATA_W-1:0] resp_rdata_1,
  output logic [DATA_W-1:0] resp_rdata_2,
  output logic              err_1,
  output logic              err_2,
  output logic              Mem_rd_1,
  output logic              Mem_rd_2,
  output logic              Mem_wr_1,
  output logic              Mem_wr_2,
  output logic [ADDR_W-1:0] Dir_Mem_1,
  output logic [ADDR_W-1:0] Dir_Mem_2,
  output logic [DATA_W-1:0] Dato_Mem_in_1,
  output logic [DATA_W-1:0] Dato_Mem_in_2,
  input  logic [DATA_W-1:0] Dato_Mem_out_1,
  input  logic [DATA_W-1:0] Dato_Mem_out_2
);

  typedef enum logic [1:0] {IDLE, ISSUE, ISSUE2, RESP} state_t;

  state_t            state, state_nxt;
  logic              v1, v2, we1, we2, ok1, ok2, conflict;
  logic [ADDR_W-1:0] a1, a2;
  logic [DATA_W-1:0] d1, d2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              accept, drv1, drv2;

  // Unsigned offset wraps for addresses below the base, so one compare covers both bounds.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return off < ADDR_W'(NUM_WORDS);
  endfunction

  // State register, bundle latch and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      v1       <= 1'b0;
      v2       <= 1'b0;
      we1      <= 1'b0;
      we2      <= 1'b0;
      ok1      <= 1'b0;
      ok2      <= 1'b0;
      conflict <= 1'b0;
      a1       <= '0;
      a2       <= '0;
      d1       <= '0;
      d2       <= '0;
      rdata1   <= '0;
      rdata2   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        v1       <= req_valid_1;
        v2       <= req_valid_2;
        we1      <= req_we_1;
        we2      <= req_we_2;
        ok1      <= in_window(req_addr_1);
        ok2      <= in_window(req_addr_2);
        conflict <= req_valid_1 & req_valid_2 & (req_addr_1 == req_addr_2) &
                    (req_we_1 | req_we_2);
        a1       <= req_addr_1;
        a2       <= req_addr_2;
        d1       <= req_wdata_1;
        d2       <= req_wdata_2;
        rdata1   <= '0;
        rdata2   <= '0;
      end
      if (drv1 && !we1) rdata1 <= Dato_Mem_out_1;
      if (drv2 && !we2) rdata2 <= Dato_Mem_out_2;
    end
  end

  // Next-state decode and memory/response outputs.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    accept        = 1'b0;
    drv1          = 1'b0;
    drv2          = 1'b0;
    resp_valid_1  = 1'b0;
    resp_valid_2  = 1'b0;
    err_1         = 1'b0;
    err_2         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        accept    = req_valid_1 | req_valid_2;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        drv1      = v1 & ok1;
        drv2      = v2 & ok2 & !conflict;
        state_nxt = conflict ? ISSUE2 : RESP;
      end
      ISSUE2: begin
        drv2      = v2 & ok2;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid_1 = v1;
        resp_valid_2 = v2;
        err_1        = v1 & !ok1;
        err_2        = v2 & !ok2;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    Mem_rd_1      = !(drv1 & !we1);
    Mem_wr_1      = !(drv1 & we1);
    Mem_rd_2      = !(drv2 & !we2);
    Mem_wr_2      = !(drv2 & we2);
    Dir_Mem_1     = drv1 ? a1 : '0;
    Dir_Mem_2     = drv2 ? a2 : '0;
    Dato_Mem_in_1 = drv1 ? d1 : '0;
    Dato_Mem_in_2 = drv2 ? d2 : '0;
    resp_rdata_1  = rdata1;
    resp_rdata_2  = rdata2;
  end

endmodule
